// File: rtl/sqg.sv
// sqg: streaming per-pixel front end of the box-counting pipeline.
// Walks a fixed 8x8 raster frame, presents the box-count read address for
// the current pixel and, one cycle later, the write address, the measure and
// the write enable for the external read-modify-write accumulator.
module sqg #(
  parameter int BOX_IDX = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BC_mode,
  input  logic [7:0] x,
  output logic       wen_sqg,
  output logic [7:0] y,
  output logic [5:0] BC_rd_addr,
  output logic [5:0] BC_wr_addr
);

  localparam int DATA_W = 8;

  // Boxes per side of the frame at this box size.
  localparam logic [5:0] NB = 6'(8 >> BOX_IDX);

  // Box index of a raster position: coarse row times boxes-per-row plus coarse column.
  function automatic logic [5:0] box_addr(input logic [5:0] c);
    logic [2:0] brow;
    logic [2:0] bcol;
    brow = c[5:3] >> BOX_IDX;
    bcol = c[2:0] >> BOX_IDX;
    return ({3'd0, brow} * NB) + {3'd0, bcol};
  endfunction

  // Quadratic measure keeps the top byte of x*x; occupancy flags any non-zero pixel.
  function automatic logic [DATA_W-1:0] measure(input logic [DATA_W-1:0] v,
                                                input logic mode);
    logic [2*DATA_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, v} * {{DATA_W{1'b0}}, v};
    if (mode)
      return (v != '0) ? DATA_W'(1) : '0;
    else
      return prod[2*DATA_W-1:DATA_W];
  endfunction

  logic [5:0]        cnt_p0;
  logic [DATA_W-1:0] y_p1;
  logic [5:0]        wr_addr_p1;
  logic              vld_p1;

  // ---- stage p0: pixel position of the sample currently on x ----
  // Raster counter; wraps 63->0 so frames run back-to-back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt_p0 <= '0;
    else
      cnt_p0 <= cnt_p0 + 6'd1;
  end

  assign BC_rd_addr = box_addr(cnt_p0);

  // ---- stage p1: registered measure, write address and write enable ----
  // Write side lags the read side by one cycle so the accumulator can read then write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y_p1       <= '0;
      wr_addr_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      y_p1       <= measure(x, BC_mode);
      wr_addr_p1 <= box_addr(cnt_p0);
      vld_p1     <= 1'b1;
    end
  end

  assign y          = y_p1;
  assign BC_wr_addr = wr_addr_p1;
  assign wen_sqg    = vld_p1;

endmodule

// File: tb/tb_sqg.sv
// Directed bench for sqg: three instances (box sizes 8, 2 and 1 pixels)
// share one stimulus stream and are checked with immediate assertions.
module tb_sqg;

  logic       CLK;
  logic       RST;
  logic       BC_mode;
  logic [7:0] x;

  logic       wen3, wen1, wen0;
  logic [7:0] y3, y1, y0;
  logic [5:0] rd3, rd1, rd0;
  logic [5:0] wr3, wr1, wr0;

  int nchk;
  int nfail;
  int n;   // bench copy of the pixel index currently presented

  sqg #(.BOX_IDX(3)) u3 (.CLK(CLK), .RST(RST), .BC_mode(BC_mode), .x(x),
                         .wen_sqg(wen3), .y(y3), .BC_rd_addr(rd3), .BC_wr_addr(wr3));
  sqg #(.BOX_IDX(1)) u1 (.CLK(CLK), .RST(RST), .BC_mode(BC_mode), .x(x),
                         .wen_sqg(wen1), .y(y1), .BC_rd_addr(rd1), .BC_wr_addr(wr1));
  sqg #(.BOX_IDX(0)) u0 (.CLK(CLK), .RST(RST), .BC_mode(BC_mode), .x(x),
                         .wen_sqg(wen0), .y(y0), .BC_rd_addr(rd0), .BC_wr_addr(wr0));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
    n = (n + 1) % 64;
  endtask

  task automatic apply(input logic mode, input logic [7:0] xv,
                       input logic [7:0] exp_y, input string tag);
    BC_mode = mode;
    x       = xv;
    step();
    chk(tag, 32'(y3), 32'(exp_y));
  endtask

  // 2x2 boxes: coarse row is cnt[5:4], coarse column is cnt[2:1], 4 boxes per row.
  function automatic logic [5:0] addr_b1(input int c);
    logic [5:0] v;
    v = 6'(c);
    return {2'b00, v[5:4], v[2:1]};
  endfunction

  initial begin
    nchk    = 0;
    nfail   = 0;
    n       = 0;
    RST     = 1'b1;
    BC_mode = 1'b0;
    x       = 8'd0;

    // Reset held for two edges
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rst_y", 32'(y3), 0);
    chk("rst_wen", 32'(wen3), 0);
    chk("rst_wr", 32'(wr0), 0);
    chk("rst_rd0", 32'(rd0), 0);
    chk("rst_rd1", 32'(rd1), 0);
    RST = 1'b0;
    n   = 0;
    chk("pre_edge_wen", 32'(wen3), 0);

    // Full frame: x=16 for 8 pixels then x=30
    for (int i = 0; i < 64; i++) begin
      chk("frame_rd3", 32'(rd3), 0);
      chk("frame_rd1", 32'(rd1), 32'(addr_b1(i)));
      chk("frame_rd0", 32'(rd0), 32'(i));
      x = (i < 8) ? 8'd16 : 8'd30;
      step();
      chk("frame_wen", 32'(wen3), 1);
      chk("frame_y3", 32'(y3), (i < 8) ? 1 : 3);
      chk("frame_y1", 32'(y1), (i < 8) ? 1 : 3);
      chk("frame_wr3", 32'(wr3), 0);
      chk("frame_wr1", 32'(wr1), 32'(addr_b1(i)));
      chk("frame_wr0", 32'(wr0), 32'(i));
    end
    // Wrapped straight into the next frame
    chk("wrap_rd0", 32'(rd0), 0);
    chk("wrap_rd1", 32'(rd1), 0);
    chk("wrap_wr0", 32'(wr0), 63);
    chk("wrap_wr1", 32'(wr1), 15);

    // Arithmetic vectors
    apply(1'b0, 8'd255, 8'd254, "sq_255");
    apply(1'b0, 8'd0,   8'd0,   "sq_0");
    apply(1'b0, 8'd15,  8'd0,   "sq_15");
    apply(1'b0, 8'd128, 8'd64,  "sq_128");
    apply(1'b1, 8'd0,   8'd0,   "occ_0");
    apply(1'b1, 8'd1,   8'd1,   "occ_1");
    apply(1'b1, 8'd200, 8'd1,   "occ_200");
    apply(1'b0, 8'd1,   8'd0,   "mode_switch_sq_1");

    // Advance to pixel 37 with y left non-zero
    BC_mode = 1'b0;
    x       = 8'd255;
    for (int k = 0; k < 64 && n != 37; k++) step();
    chk("pre_rst_n", 32'(n), 37);
    chk("pre_rst_y", 32'(y3), 254);
    chk("pre_rst_rd1", 32'(rd1), 10);
    chk("pre_rst_rd0", 32'(rd0), 37);

    // Asynchronous reset mid-cycle
    #2;
    RST = 1'b1;
    #1;
    chk("arst_y", 32'(y3), 0);
    chk("arst_wen", 32'(wen3), 0);
    chk("arst_wr0", 32'(wr0), 0);
    chk("arst_rd0", 32'(rd0), 0);
    @(posedge CLK);
    #1;
    chk("arst_hold_y", 32'(y0), 0);
    chk("arst_hold_wen", 32'(wen0), 0);
    #1;
    RST = 1'b0;
    n   = 0;
    BC_mode = 1'b0;
    x       = 8'd128;
    chk("rel_rd0", 32'(rd0), 0);
    chk("rel_rd1", 32'(rd1), 0);
    step();
    chk("rel_y", 32'(y0), 64);
    chk("rel_wen", 32'(wen0), 1);
    chk("rel_wen1", 32'(wen1), 1);
    chk("rel_wr0", 32'(wr0), 0);
    chk("rel_rd0_next", 32'(rd0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
